// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Brief    : EX/MEM -> MEM/WB pipeline bus for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic        Regwrite;
    logic        MemtoReg;
    logic        Memread;
    logic        Memwrite;
    logic [1:0]  size;
    logic        unsign;
    logic [31:0] aluresultout;
    logic [31:0] memreadresultout;
    logic [4:0]  rdout;
    logic        Regwriteout;
    logic        MemtoRegout;
    logic        stall;
    logic        fault;

    modport master (
        output aluresult, writedata, rd, Regwrite, MemtoReg, Memread, Memwrite, size, unsign,
        input  aluresultout, memreadresultout, rdout, Regwriteout, MemtoRegout, stall, fault
    );

    modport slave (
        input  aluresult, writedata, rd, Regwrite, MemtoReg, Memread, Memwrite, size, unsign,
        output aluresultout, memreadresultout, rdout, Regwriteout, MemtoRegout, stall, fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline MEM stage with multi-cycle byte-lane data memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_stage_if.slave    bus
);
    localparam int c_ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_rdata;

    logic                w_memop;
    logic                w_load;
    logic                w_misalign;
    logic                w_fault;
    logic                w_stall;
    logic                w_commit;
    logic [c_ADDR_W-1:0] w_idx;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_ext;
    logic                w_unused_addr;

    assign w_memop       = bus.Memread | bus.Memwrite;
    assign w_load        = bus.Memread & ~bus.Memwrite;
    assign w_idx         = bus.aluresult[c_ADDR_W+1:2];
    assign w_unused_addr = ^bus.aluresult[31:c_ADDR_W+2];

    always_comb begin
        w_misalign = 1'b0;
        case (bus.size)
            2'b01:   w_misalign = bus.aluresult[0];
            2'b10:   w_misalign = |bus.aluresult[1:0];
            2'b11:   w_misalign = 1'b1;
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_fault  = ~rst & w_memop & w_misalign;
    assign w_stall  = ~rst & (((r_state == S_IDLE) & w_memop & ~w_misalign) | (r_state == S_BUSY));
    assign w_commit = ~rst & (r_state == S_BUSY) & (r_count == 4'd0);

    assign bus.aluresultout     = bus.aluresult;
    assign bus.rdout            = bus.rd;
    assign bus.MemtoRegout      = bus.MemtoReg;
    assign bus.stall            = w_stall;
    assign bus.fault            = w_fault;
    assign bus.Regwriteout      = bus.Regwrite & ~w_stall & ~w_fault & ~rst;
    assign bus.memreadresultout = r_rdata;

    // Store data is replicated across lanes; the byte enables pick the target lane(s).
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.writedata;
        case (bus.size)
            2'b00: begin
                w_be    = 4'b0001 << bus.aluresult[1:0];
                w_wdata = {4{bus.writedata[7:0]}};
            end
            2'b01: begin
                w_be    = bus.aluresult[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.writedata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.writedata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (w_commit && bus.Memwrite && w_be[gi]) begin
                    r_lane[w_idx] <= w_wdata[8*gi +: 8];
                end
            end

            assign w_word[8*gi +: 8] = r_lane[w_idx];
        end
    endgenerate

    always_comb begin
        w_byte = w_word[7:0];
        case (bus.aluresult[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = bus.aluresult[1] ? w_word[31:16] : w_word[15:0];

        case (bus.size)
            2'b00:   w_load_ext = bus.unsign ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = bus.unsign ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !w_misalign) begin
                        r_state <= S_BUSY;
                        r_count <= 4'(LATENCY - 1);
                    end
                end
                S_BUSY: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        if (w_load) begin
                            r_rdata <= w_load_ext;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, shall set the number of 32-bit words in the internal data memory (power of two).
REQ-002 Parameter LATENCY, default 2, legal 1..15, shall set the memory busy cycles per access.
REQ-003 The ports shall be:
- clk  in  1  rising-edge clock; one clock only
- rst  in  1  synchronous, active-high reset
- aluresult  in  32  effective address, or ALU result for non-memory ops
- writedata  in  32  store data; byte in [7:0], half in [15:0]
- rd  in  5  destination register
- Regwrite, MemtoReg, Memread, Memwrite  in  1 each  control from EX/MEM
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsign  in  1  zero-extend loads when 1
- aluresultout  out  32  to MEM/WB
- memreadresultout  out  32  extended load data to MEM/WB
- rdout  out  5  to MEM/WB
- Regwriteout, MemtoRegout  out  1 each  to MEM/WB
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high
- fault  out  1  misaligned or illegal access this cycle

Function
REQ-004 aluresultout, rdout and MemtoRegout shall be combinational copies of aluresult, rd and MemtoReg.
REQ-005 A memory op shall be Memread or Memwrite high. Memread and Memwrite both high shall be treated as a store.
REQ-006 fault shall be 1, combinationally, for a memory op with size=11, a half access with aluresult[0]=1, or a word access with aluresult[1:0]!=00. It shall be 0 otherwise and during rst.
REQ-007 A faulting op shall start no access, shall not modify memory, and shall leave stall at 0.
REQ-008 The FSM shall have three states: IDLE, BUSY and DONE.
- IDLE, non-faulting memory op present: stall=1; load count=LATENCY-1; go to BUSY.
- BUSY: stall=1. If count!=0, decrement. If count==0, perform the access and go to DONE.
- DONE: stall=0. Return to IDLE unconditionally.
REQ-009 A non-faulting memory op shall therefore stall exactly LATENCY+1 cycles and complete in the following DONE cycle. Upstream holds all inputs stable while stall=1.
REQ-010 Word index shall be aluresult[log2(DEPTH_WORDS)+1:2]. Higher address bits shall be ignored, so addresses alias modulo DEPTH_WORDS*4.
REQ-011 Lanes shall be little-endian.
- Byte stores write lane aluresult[1:0] with writedata[7:0].
- Half stores write lane aluresult[1] with writedata[15:0].
- Other bytes of the word shall be preserved.
REQ-012 A store shall write memory only on the clock edge leaving BUSY with count==0.
REQ-013 Loads shall extract the addressed byte, half or word on that same edge and register it into memreadresultout.
- Sign-extend when unsign=0; zero-extend when unsign=1.
- Word loads ignore unsign.
REQ-014 memreadresultout shall hold its value until the next load completes; stores and non-memory ops shall not change it.
REQ-015 Regwriteout shall equal Regwrite AND NOT stall AND NOT fault AND NOT rst, so MEM/WB captures a bubble while stalled.
REQ-016 A non-memory op shall pass through with stall=0 and no memory access in the same cycle.

Reset
REQ-017 With rst high at a clock edge, the block shall set state=IDLE, count=0 and memreadresultout=0.
REQ-018 While rst is high, stall, fault and Regwriteout shall be 0 and no memory write shall occur.
REQ-019 Reset during BUSY shall abort the access: no store is committed and memreadresultout is cleared.
REQ-020 Memory contents shall not be affected by reset.

Verification (LATENCY=2)
REQ-021 sw 0xDEADBEEF at 0x10, then lw 0x10 -> each op stalls 3 cycles; in the lw DONE cycle memreadresultout=0xDEADBEEF and Regwriteout=1.
REQ-022 sb writedata=0x000000AA at 0x13, then lb 0x13 -> 0xFFFFFFAA; then lbu 0x13 -> 0x000000AA; then lw 0x10 -> 0xAAADBEEF.
REQ-023 lh at 0x11 with Regwrite=1 -> fault=1, stall=0 and Regwriteout=0 that cycle; a following lw 0x10 is unchanged.
REQ-024 sw 0x12345678 at 0x20, rst pulsed in the second BUSY cycle -> state IDLE next cycle, memreadresultout=0; lw 0x20 returns the prior contents.
REQ-025 Memread=Memwrite=0, Regwrite=1, aluresult=0x55, rd=7 -> stall=0; same cycle Regwriteout=1, aluresultout=0x55, rdout=7.
REQ-026 sw 0xCAFEF00D at 0x400 (DEPTH_WORDS=256), then lw 0x000 -> 0xCAFEF00D.
